// File: rtl/aabb_minmax_accum.sv
// Streaming per-object AABB accumulator over IEEE-754 single vertices.
// Optional macro AABB_NAN_FILTER_EN: NaN vertices are accepted but not folded in.
module aabb_minmax_accum #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [31:0]      in_z,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [31:0]      min_x,
  output logic [31:0]      min_y,
  output logic [31:0]      min_z,
  output logic [31:0]      max_x,
  output logic [31:0]      max_y,
  output logic [31:0]      max_z,
  output logic [CNT_W-1:0] vcount,
  output logic             out_empty,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                state, state_nx;
  logic [2:0][31:0]      vin, mn_q, mx_q, mn_nx, mx_nx;
  logic [CNT_W-1:0]      cnt_q, cnt_nx;
  logic                  rdy_q, empty_q;
  logic                  take, vtx_ok;

  // Total-order key: negatives fully inverted, positives get the sign bit set.
  function automatic logic [31:0] fkey(input logic [31:0] v);
    return v[31] ? ~v : {1'b1, v[30:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  assign vin  = {in_z, in_y, in_x};
  assign take = in_valid && rdy_q;

`ifdef AABB_NAN_FILTER_EN
  assign vtx_ok = !(is_nan(in_x) || is_nan(in_y) || is_nan(in_z));
`else
  assign vtx_ok = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    mn_nx    = mn_q;
    mx_nx    = mx_q;
    cnt_nx   = cnt_q;
    case (state)
      IDLE: begin
        if (take) begin
          // A filtered vertex in IDLE clears the box so an all-NaN packet reports empty.
          if (vtx_ok) begin
            mn_nx  = vin;
            mx_nx  = vin;
            cnt_nx = CNT_W'(1);
          end else begin
            mn_nx  = '0;
            mx_nx  = '0;
            cnt_nx = '0;
          end
          if (in_last)     state_nx = HOLD;
          else if (vtx_ok) state_nx = ACCUM;
        end
      end
      ACCUM: begin
        if (take) begin
          if (vtx_ok) begin
            for (int unsigned i = 0; i < 3; i++) begin
              if (fkey(vin[i]) < fkey(mn_q[i])) mn_nx[i] = vin[i];
              if (fkey(vin[i]) > fkey(mx_q[i])) mx_nx[i] = vin[i];
            end
            if (cnt_q != '1) cnt_nx = cnt_q + CNT_W'(1);
          end
          if (in_last) state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mn_q    <= '0;
      mx_q    <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state   <= state_nx;
      mn_q    <= mn_nx;
      mx_q    <= mx_nx;
      cnt_q   <= cnt_nx;
      rdy_q   <= (state_nx != HOLD);
      empty_q <= (cnt_nx == '0);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state == HOLD);
  assign out_empty = empty_q;
  assign vcount    = cnt_q;
  assign min_x     = mn_q[0];
  assign min_y     = mn_q[1];
  assign min_z     = mn_q[2];
  assign max_x     = mx_q[0];
  assign max_y     = mx_q[1];
  assign max_z     = mx_q[2];

endmodule
